uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte producers: requester 0 is the CPU store path (writes to UART_DATA_ADDR 0x10000000) and requester 1 is the debug/monitor port. The block sits between those producers and the UART's `tx_start`/`tx_data_in`/`tx_busy` pins. It arbitrates between the requesters, issues exactly one `tx_start` pulse per accepted byte, and tracks completion through `tx_busy`, with a timeout and per-requester byte counters.

---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the CPU store path
// (requester 0) and the debug/monitor port (requester 1). Issues one tx_start
// pulse per accepted byte, follows tx_busy to completion, and flags a UART
// that never goes busy.
// Build option: define UART_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority.
module uart_tx_arbiter #(
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data_out,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  input  logic              err_clear,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sent_count0,
  output logic [CNT_W-1:0]  sent_count1
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Preloaded one short of BUSY_TIMEOUT: the error flag is registered, so it
  // becomes visible BUSY_TIMEOUT+1 cycles after the tx_start cycle.
  localparam logic [7:0] TMO_LOAD = 8'(BUSY_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] tmo_cnt;
  logic       can_accept;
  logic       win0;
  logic       win1;
  logic       tmo_fire;

`ifdef UART_ARB_RR_EN
  logic last_served;

  // Round-robin winner: on a tie the requester not served last wins
  always_comb begin
    win0 = req0_valid && (!req1_valid || last_served);
    win1 = req1_valid && !win0;
  end

  // Remember who was served last; moves only on an acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (req0_ready) begin
      last_served <= 1'b0;
    end else if (req1_ready) begin
      last_served <= 1'b1;
    end
  end
`else
  // Fixed priority winner: requester 0 always wins a tie
  always_comb begin
    win0 = req0_valid;
    win1 = req1_valid && !req0_valid;
  end
`endif

  // Ready strobes: only in IDLE with the UART free; held low during reset
  always_comb begin
    can_accept = (state == ST_IDLE) && !tx_busy && !reset;
    req0_ready = can_accept && win0;
    req1_ready = can_accept && win1;
    tx_start   = (state == ST_START);
    tmo_fire   = (state == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt == '0);
  end

  // Transfer FSM, latched byte, owner and per-requester byte counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      tx_data_out <= '0;
      grant       <= '0;
      sent_count0 <= '0;
      sent_count1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_ready) begin
            tx_data_out <= req0_data;
            grant       <= 2'b01;
            sent_count0 <= sent_count0 + 1'b1;
            state       <= ST_START;
          end else if (req1_ready) begin
            tx_data_out <= req1_data;
            grant       <= 2'b10;
            sent_count1 <= sent_count1 + 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          tmo_cnt <= TMO_LOAD;
          state   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_cnt == '0) begin
            grant <= '0;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (tmo_fire) begin
      timeout_err <= 1'b1;
    end else if (err_clear) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: ready-logic vector table, a small UART busy
// model, and a scoreboard of expected {grant, byte} per tx_start pulse.
module tb_uart_tx_arbiter;

  localparam int DW  = 8;
  localparam int TMO = 15;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data_out;
  logic          tx_busy;
  logic [1:0]    grant;
  logic          err_clear = 1'b0;
  logic          timeout_err;
  logic [CW-1:0] sent_count0;
  logic [CW-1:0] sent_count1;

  uart_tx_arbiter #(
    .DATA_W      (DW),
    .BUSY_TIMEOUT(TMO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data_out(tx_data_out),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .err_clear  (err_clear),
    .timeout_err(timeout_err),
    .sent_count0(sent_count0),
    .sent_count1(sent_count1)
  );

  always #5 clk = ~clk;

  // UART model: busy rises uart_dly cycles after tx_start, stays uart_len cycles
  logic busy_force = 1'b0;
  logic busy_uart  = 1'b0;
  bit   uart_en    = 1'b1;
  int   uart_dly   = 2;
  int   uart_len   = 10;
  int   dly_left   = 0;
  int   hold_left  = 0;
  assign tx_busy = busy_force | busy_uart;

  always @(negedge clk) begin
    if (reset) begin
      busy_uart = 1'b0;
      dly_left  = 0;
      hold_left = 0;
    end else if (tx_start && uart_en) begin
      dly_left  = uart_dly;
      hold_left = uart_len;
    end else if (dly_left > 0) begin
      dly_left--;
      if (dly_left == 0) busy_uart = 1'b1;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) busy_uart = 1'b0;
    end
  end

  // Observed transfers, one record per tx_start cycle
  logic [9:0] obs_mem [64];
  int         obs_n = 0;
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      obs_mem[obs_n % 64] = {grant, tx_data_out};
      obs_n++;
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         obs_rd = 0;
  int         ec0 = 0;
  int         ec1 = 0;
  logic [9:0] exp_q [$];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       busy;
    logic       exp_r0;
    logic       exp_r1;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event expected event", name);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt0"}, 32'(sent_count0), 32'(ec0 % (1 << CW)));
    chk({tag, "_cnt1"}, 32'(sent_count1), 32'(ec1 % (1 << CW)));
  endtask

  // Serve queued bytes on both requesters, holding valid until accepted
  task automatic run_queues(input int budget);
    int cyc;
    bit a0;
    bit a1;
    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
      @(negedge clk);
      req0_valid = (q0.size() != 0);
      req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
      req1_valid = (q1.size() != 0);
      req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
      #1;
      chk("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      cyc++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (q0.size() != 0 || q1.size() != 0) begin
      bound_fail("run_queues");
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(grant == 2'b00 && !tx_busy && !tx_start) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) bound_fail("wait_idle");
  endtask

  // Compare observed tx_start records against the expected queue in order
  task automatic drain(input string tag);
    logic [9:0] e;
    chk({tag, "_nstart"}, 32'(obs_n - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_n) begin
        chk({tag, "_xfer"}, 32'(obs_mem[obs_rd % 64]), 32'(e));
        obs_rd++;
      end
    end
    obs_rd = obs_n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ec0 = 0;
    ec1 = 0;
    obs_rd = obs_n;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h88, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    // Reset state, with both requesters asserting valid
    #1 reset = 1'b1;
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data_out), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk_counts("rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Ready logic in IDLE; valid withdrawn before the edge so nothing is taken
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0;
      req0_data  = vecs[i].d0;
      req1_valid = vecs[i].v1;
      req1_data  = vecs[i].d1;
      busy_force = vecs[i].busy;
      #1;
      chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].exp_r0));
      chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].exp_r1));
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      busy_force = 1'b0;
    end
    @(negedge clk);
    chk_counts("vec");

    // Single byte from requester 0
    uart_dly = 2;
    uart_len = 10;
    q0.push_back(8'h41);
    exp_q.push_back({2'b01, 8'h41});
    ec0++;
    run_queues(100);
    wait_idle(100);
    drain("single");
    chk_counts("single");
    chk("single_grant_idle", 32'(grant), 32'd0);

    // Tie: both requesters hold three bytes each
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(8'(8'h10 + i));
      q1.push_back(8'(8'h20 + i));
    end
`ifdef UART_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b01, 8'(8'h10 + i)});
      exp_q.push_back({2'b10, 8'(8'h20 + i)});
    end
`else
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b01, 8'(8'h10 + i)});
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b10, 8'(8'h20 + i)});
`endif
    ec0 += 3;
    ec1 += 3;
    run_queues(300);
    wait_idle(100);
    drain("tie");
    chk_counts("tie");

    // UART still busy in IDLE: req1 must wait, then go on the next edge
    @(negedge clk);
    busy_force = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h5A;
    exp_q.push_back({2'b10, 8'h5A});
    ec1++;
    for (int i = 0; i < 4; i++) begin
      #1 chk("busy_idle_ready1", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    busy_force = 1'b0;
    #1 chk("busy_fall_ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    chk("busy_fall_start", 32'(tx_start), 32'd1);
    chk("busy_fall_data", 32'(tx_data_out), 32'h5A);
    chk("busy_fall_grant", 32'(grant), 32'd2);
    req1_valid = 1'b0;
    wait_idle(100);
    drain("busy_idle");

    // Timeout: busy never rises
    uart_en = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_data  = 8'(8'h77 + t);
      exp_q.push_back({2'b01, 8'(8'h77 + t)});
      ec0++;
      #1 chk("tmo_ready0", 32'(req0_ready), 32'd1);
      @(negedge clk);
      chk("tmo_start", 32'(tx_start), 32'd1);
      req0_valid = 1'b0;
      for (int i = 1; i <= TMO + 1; i++) begin
        @(negedge clk);
        if (i <= TMO) chk("tmo_early_err", 32'(timeout_err), 32'd0);
        if (t == 1 && i == TMO) err_clear = 1'b1;
      end
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      chk("tmo_grant_idle", 32'(grant), 32'd0);
      err_clear = 1'b0;
      @(negedge clk);
      chk("tmo_err_hold", 32'(timeout_err), 32'd1);
      if (t == 0) begin
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("tmo_err_cleared", 32'(timeout_err), 32'd0);
      end
    end
    uart_en = 1'b1;
    drain("timeout");

    // Reset while waiting for the UART to finish
    @(negedge clk);
    req1_valid = 1'b1;
    req1_data  = 8'h33;
    exp_q.push_back({2'b10, 8'h33});
    #1 chk("mid_ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_grant", 32'(grant), 32'd2);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    drain("mid");
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    reset = 1'b1;
    ec0 = 0;
    ec1 = 0;
    #1;
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_data", 32'(tx_data_out), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_err", 32'(timeout_err), 32'd0);
    chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
    chk("mid_rst_ready1", 32'(req1_ready), 32'd0);
    chk_counts("mid_rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs_rd = obs_n;
    q0.push_back(8'hA0);
    q1.push_back(8'hB0);
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB0});
    ec0++;
    ec1++;
    run_queues(100);
    wait_idle(100);
    drain("post_rst_tie");
    chk_counts("post_rst");

    // Counter wrap on requester 1 (CNT_W = 4)
    uart_dly = 1;
    uart_len = 1;
    for (int i = 0; i < 14; i++) begin
      q1.push_back(8'(8'hC0 + i));
      exp_q.push_back({2'b10, 8'(8'hC0 + i)});
    end
    ec1 += 14;
    run_queues(400);
    wait_idle(100);
    drain("wrap_pre");
    chk("wrap_pre_cnt1", 32'(sent_count1), 32'd15);
    q1.push_back(8'hEE);
    exp_q.push_back({2'b10, 8'hEE});
    ec1++;
    run_queues(100);
    wait_idle(100);
    drain("wrap");
    chk("wrap_cnt1", 32'(sent_count1), 32'd0);
    chk("wrap_cnt0", 32'(sent_count0), 32'd1);
    chk_counts("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
